// File: rtl/fp_convert_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter feeding a shared 12-bit two's-complement to sign/exp3/sig4 float converter.
// Latency: out_valid one edge after the accept edge; at most one sample per 3 cycles.
// Backpressure: the result holds until out_ready, and no requester is granted while a result is in flight.
module fp_convert_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [12*N_REQ-1:0]  req_data,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sign,
   output logic [2:0]           out_exp,
   output logic [3:0]           out_sig,
   output logic [2:0]           out_id,
   output logic                 out_sat
);

   typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

   typedef struct packed {
      logic       sign;
      logic [2:0] exp;
      logic [3:0] sig;
      logic       sat;
      logic [2:0] id;
   } res_t;

   state_t      state_q, state_d;
   logic [2:0]  last_grant;
   logic [2:0]  winner;
   logic [2:0]  cand;
   logic        found;
   logic        accept;
   logic [7:0]  valid_ext;
   logic [11:0] win_dat;
   logic [11:0] sample_q;
   logic [2:0]  sample_id;
   res_t        res_q, res_d;
   logic        out_valid_q;

   // Round-robin search starting one past the previous winner.
   always_comb begin
      found     = 1'b0;
      winner    = last_grant;
      cand      = 3'd0;
      valid_ext = 8'(req_valid);
      for (int off = 1; off <= N_REQ; off++) begin
         cand = 3'((int'(last_grant) + off) % N_REQ);
         if (!found && valid_ext[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign accept = (state_q == IDLE) && en && found && rst_n;

   always_comb begin
      win_dat   = 12'd0;
      req_ready = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (winner == 3'(k)) begin
            win_dat      = req_data[12*k +: 12];
            req_ready[k] = accept;
         end
      end
   end

   // Converter operates on the latched sample during CONV.
   logic        c_sign;
   logic [11:0] c_mag;
   logic [2:0]  c_exp_raw;
   logic [4:0]  c_win;
   logic [3:0]  c_sig_raw;
   logic        c_rnd;
   logic        c_sat;

   always_comb begin
      c_sign    = sample_q[11];
      c_mag     = c_sign ? (~sample_q + 12'd1) : sample_q;
      c_exp_raw = 3'd0;
      for (int i = 4; i <= 10; i++) begin
         if (c_mag[i]) c_exp_raw = 3'(i - 3);
      end
      // Window {sig, round}: mag[p:p-3] and mag[p-4], with a zero round bit when p=3.
      c_win     = 5'({c_mag, 1'b0} >> c_exp_raw);
      c_sig_raw = c_win[4:1];
      c_rnd     = c_win[0];
      c_sat     = (c_mag[10:7] == 4'hF) || (sample_q == 12'h800);

      res_d      = '0;
      res_d.sign = c_sign;
      res_d.id   = sample_id;
      res_d.sat  = c_sat;
      if (c_sat) begin
         res_d.exp = 3'b111;
         res_d.sig = 4'hF;
      end else if (c_rnd && (c_sig_raw == 4'hF)) begin
         res_d.exp = c_exp_raw + 3'd1;
         res_d.sig = 4'h8;
      end else begin
         res_d.exp = c_exp_raw;
         res_d.sig = c_sig_raw + {3'd0, c_rnd};
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = CONV;
         CONV:    state_d = HOLD;
         HOLD:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_grant  <= 3'(N_REQ - 1);
         sample_q    <= '0;
         sample_id   <= '0;
         res_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            sample_q   <= win_dat;
            sample_id  <= winner;
            last_grant <= winner;
         end
         if (state_q == CONV) begin
            res_q       <= res_d;
            out_valid_q <= 1'b1;
         end else if ((state_q == HOLD) && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_sign  = res_q.sign;
   assign out_exp   = res_q.exp;
   assign out_sig   = res_q.sig;
   assign out_id    = res_q.id;
   assign out_sat   = res_q.sat;

endmodule

// File: doc/fp_convert_arbiter.md
FP_CONVERT_ARBITER -- requirements
Module: fp_convert_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing the converter (2..8).
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: en  input  1  grant enable; low blocks new grants, an in-flight conversion still completes.
REQ-005 Port: req_valid  input  N_REQ  per-requester sample valid.
REQ-006 Port: req_data  input  12*N_REQ  packed two's-complement samples, requester k in bits [12k+11:12k].
REQ-007 Port: req_ready  output  N_REQ  per-requester accept strobe, at most one bit high per cycle.
REQ-008 Port: out_valid  output  1  converted result valid.
REQ-009 Port: out_ready  input  1  downstream accepts result.
REQ-010 Port: out_sign / out_exp / out_sig  output  1 / 3 / 4  converted float fields.
REQ-011 Port: out_id  output  3  index of the requester that owns the result.
REQ-012 Port: out_sat  output  1  result was saturated.

Function
REQ-013 FSM states SHALL be IDLE, CONV and HOLD; the only transitions are IDLE->CONV, CONV->HOLD and HOLD->IDLE.
REQ-014 In IDLE with en=1 and any req_valid, one winner SHALL be chosen combinationally by round-robin.
- Search order: starts at last_grant+1 and wraps modulo N_REQ.
REQ-015 Winner handling in IDLE:
- req_ready[winner]=1 in that cycle.
- At the clock edge: sample latched, winner index stored in last_grant, state->CONV.
REQ-016 req_ready SHALL be all-zero in CONV and HOLD, and in IDLE when en=0 or no req_valid.
REQ-017 In CONV the latched sample SHALL be converted and the result registered; state->HOLD with out_valid=1 on that edge.
- Latency: out_valid rises one edge after the accept edge.
REQ-018 In HOLD, out_* SHALL stay stable until out_valid&out_ready at an edge; then out_valid->0 and state->IDLE.
- Peak throughput: one sample per 3 cycles.
REQ-019 Conversion, sign and magnitude:
- sign = d[11].
- mag = d if d[11]=0, else (~d+1) truncated to 12 bits.
REQ-020 Conversion, exponent:
- p = highest set bit of mag[10:4], or p=3 if mag[10:4]=0.
- exp = p-3 (range 0..7).
REQ-021 Conversion, significand:
- sig = mag[p:p-3].
- Round bit r = mag[p-4] when p>3, else r=0.
REQ-022 Conversion, rounding:
- If r=1 and sig=1111: sig=1000, exp=exp+1.
- Else if r=1: sig=sig+1.
REQ-023 Conversion, saturation:
- Condition: mag[10:7]=1111, or d=0x800.
- Result: exp=111, sig=1111, out_sat=1; otherwise out_sat=0.
REQ-024 en falling while in CONV or HOLD SHALL NOT abort the transaction; the FSM stays in IDLE until en=1.
REQ-025 A requester whose req_valid is held high SHALL be granted within N_REQ grants of its first valid cycle (starvation-free).
REQ-026 out_ready high while out_valid=0 SHALL have no effect.
REQ-027 req_valid changes while not in IDLE SHALL be ignored; no sample is lost, because only req_ready commits a transfer.

Reset
REQ-028 On rst_n=0, regardless of clock or state, the block SHALL enter IDLE with the following values.
- out_valid=0, out_sign=0, out_exp=000, out_sig=0000, out_id=0, out_sat=0.
- req_ready all-zero, last_grant=N_REQ-1.
REQ-029 Reset mid-transaction SHALL discard the in-flight sample with no output produced.
REQ-030 The first grant after reset SHALL go to the lowest-index valid requester.

Verification
REQ-031 Basic conversions, single requester 0, out_ready=1:
- 0x000 -> sign0 exp000 sig0000 sat0.
- 0xFFF -> sign1 exp000 sig0001 sat0.
- 0x0F8 -> sign0 exp101 sig1000 (round overflow).
REQ-032 Saturation:
- 0x7FF -> sign0 exp111 sig1111 sat1.
- 0x800 -> sign1 exp111 sig1111 sat1.
- 0x780 -> sat1.
REQ-033 Arbitration: all four req_valid held high after reset with out_ready=1.
- Grant order 0,1,2,3,0.
- out_id matches each grant.
- One req_ready pulse every 3 cycles.
REQ-034 Backpressure: out_ready=0 for 10 cycles after out_valid.
- Outputs stay constant.
- req_ready stays 0.
- Releasing out_ready completes the transfer in one edge.
REQ-035 Reset and enable boundaries:
- rst_n pulsed low in CONV -> outputs reset asynchronously, no result emitted, next grant goes to requester 0.
- en=0 during HOLD -> current result delivered, no further grants until en=1.
